pru1_jtag_scan_master: RTL

Host-side JTAG scan initiator for the pru1 debug path. It accepts IR-scan, DR-scan and TAP-reset commands over a valid/ready interface. It drives TCK/TMS/TDI into an IEEE 1149.1 TAP, such as the CPU's debug TAP on a test board or a bench model of it, and returns the captured TDO bits. The IR and DR lengths match the 38-bit debug data register, so on-chip test logic can run debug-module scans without an external cable.

---
 rtl/pru1_jtag_scan_master_if.sv | 28 ++
 rtl/pru1_jtag_scan_master.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/pru1_jtag_scan_master_if.sv
// rtl/pru1_jtag_scan_master_if.sv - command/response bus of the pru1 JTAG scan master
// Signals:
//   cmd_valid, cmd_ready, cmd_op[1:0], cmd_len[5:0], cmd_data[MAX_LEN-1:0]  command channel
//   rsp_valid, rsp_ready, rsp_data[MAX_LEN-1:0], rsp_error                  response channel
// Modports: master = host issuing scans, slave = the scan master block.
interface pru1_jtag_scan_master_if #(
   parameter int MAX_LEN = 38
);
   logic               cmd_valid;
   logic               cmd_ready;
   logic [1:0]         cmd_op;
   logic [5:0]         cmd_len;
   logic [MAX_LEN-1:0] cmd_data;
   logic               rsp_valid;
   logic               rsp_ready;
   logic [MAX_LEN-1:0] rsp_data;
   logic               rsp_error;

   modport master (
      output cmd_valid, cmd_op, cmd_len, cmd_data, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_data, rsp_error
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_len, cmd_data, rsp_ready,
      output cmd_ready, rsp_valid, rsp_data, rsp_error
   );
endinterface

// File: rtl/pru1_jtag_scan_master.sv
// rtl/pru1_jtag_scan_master.sv - JTAG scan initiator driving an IEEE 1149.1 TAP
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   bus (slave)       command/response channels (see pru1_jtag_scan_master_if)
//   tck, tms, tdi     registered JTAG outputs to the TAP
//   tdo               JTAG data from the TAP, already synchronised to clk
module pru1_jtag_scan_master #(
   parameter int CLK_DIV = 2,
   parameter int MAX_LEN = 38
) (
   input  logic                   clk,
   input  logic                   reset,
   pru1_jtag_scan_master_if.slave bus,
   output logic                   tck,
   output logic                   tms,
   output logic                   tdi,
   input  logic                   tdo
);
   typedef enum logic [2:0] {INIT_TLR, IDLE, PRE, SHIFT, POST, RSP} state_t;

   localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
   localparam logic [6:0] LEN_MAX  = 7'(MAX_LEN);
   localparam logic [1:0] OP_IR    = 2'd1;
   localparam logic [1:0] OP_RST   = 2'd2;
   localparam logic [1:0] OP_BAD   = 2'd3;

   state_t             state;
   logic [7:0]         div_cnt;
   logic [2:0]         step;      // TCK index within INIT_TLR / PRE / POST
   logic [5:0]         bit_idx;   // current shift bit
   logic [5:0]         len_q;
   logic               ir_q;
   logic               rst_op_q;  // INIT_TLR run on behalf of a TAP reset command needs a response
   logic [MAX_LEN-1:0] data_q;

   logic       tck_active;
   logic       phase_end;
   logic       tck_rise;
   logic       tck_fall;
   logic       last_bit;
   logic [2:0] pre_last;
   logic       cmd_bad;

   assign tck_active = (state == INIT_TLR) || (state == PRE) || (state == SHIFT) || (state == POST);
   assign phase_end  = (div_cnt == DIV_LAST);
   assign tck_rise   = tck_active && phase_end && !tck;
   assign tck_fall   = tck_active && phase_end && tck;
   assign last_bit   = (bit_idx == len_q - 6'd1);
   assign pre_last   = ir_q ? 3'd3 : 3'd2;
   assign cmd_bad    = (bus.cmd_op == OP_BAD) ||
                       ((bus.cmd_op != OP_RST) &&
                        ((bus.cmd_len == 6'd0) || ({1'b0, bus.cmd_len} > LEN_MAX)));

   assign bus.cmd_ready = (state == IDLE);
   assign bus.rsp_valid = (state == RSP);

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= INIT_TLR;
         div_cnt       <= '0;
         step          <= '0;
         bit_idx       <= '0;
         len_q         <= '0;
         ir_q          <= 1'b0;
         rst_op_q      <= 1'b0;
         data_q        <= '0;
         tck           <= 1'b0;
         tms           <= 1'b1;
         tdi           <= 1'b0;
         bus.rsp_data  <= '0;
         bus.rsp_error <= 1'b0;
      end else begin
         // TCK divider: CLK_DIV clk low, CLK_DIV clk high; parked low outside active states
         if (tck_active) begin
            if (phase_end) begin
               div_cnt <= '0;
               tck     <= ~tck;
            end else begin
               div_cnt <= div_cnt + 8'd1;
            end
         end

         // tms/tdi for the next TCK are set on the falling edge that ends the current one
         case (state)
            INIT_TLR: begin
               if (tck_fall) begin
                  if (step == 3'd5) begin
                     state <= rst_op_q ? RSP : IDLE;
                  end else begin
                     step <= step + 3'd1;
                     tms  <= (step < 3'd4);
                  end
               end
            end

            IDLE: begin
               if (bus.cmd_valid) begin
                  len_q        <= bus.cmd_len;
                  data_q       <= bus.cmd_data;
                  ir_q         <= (bus.cmd_op == OP_IR);
                  rst_op_q     <= (bus.cmd_op == OP_RST);
                  step         <= '0;
                  bit_idx      <= '0;
                  div_cnt      <= '0;
                  bus.rsp_data <= '0;
                  if (cmd_bad) begin
                     bus.rsp_error <= 1'b1;
                     state         <= RSP;
                  end else begin
                     bus.rsp_error <= 1'b0;
                     tms           <= 1'b1;
                     state         <= (bus.cmd_op == OP_RST) ? INIT_TLR : PRE;
                  end
               end
            end

            PRE: begin
               if (tck_fall) begin
                  if (step == pre_last) begin
                     state   <= SHIFT;
                     bit_idx <= '0;
                     tms     <= (len_q == 6'd1);
                     tdi     <= data_q[0];
                  end else begin
                     step <= step + 3'd1;
                     // only IR scans send a second TMS=1 (Select-IR-Scan)
                     tms  <= ir_q && (step == 3'd0);
                  end
               end
            end

            SHIFT: begin
               if (tck_rise) begin
                  bus.rsp_data[bit_idx] <= tdo;
               end
               if (tck_fall) begin
                  if (last_bit) begin
                     state <= POST;
                     step  <= '0;
                     tms   <= 1'b1;
                     tdi   <= 1'b0;
                  end else begin
                     bit_idx <= bit_idx + 6'd1;
                     tms     <= (bit_idx + 6'd2 == len_q);
                     tdi     <= data_q[bit_idx + 6'd1];
                  end
               end
            end

            POST: begin
               if (tck_fall) begin
                  if (step == 3'd1) begin
                     state <= RSP;
                  end else begin
                     step <= 3'd1;
                     tms  <= 1'b0;
                  end
               end
            end

            RSP: begin
               if (bus.rsp_ready) begin
                  state <= IDLE;
               end
            end

            default: state <= INIT_TLR;
         endcase
      end
   end
endmodule
